// File: rtl/ram_if_pkg.sv
// Shared definitions for the trigger/ready RAM initiator: FSM states,
// default timing constants and bus direction encoding.
package ram_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned MIN_WAIT_DEF = 4;
  localparam int unsigned TIMEOUT_DEF  = 255;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram_initiator_if.sv
// Core request/response channel plus RAM bus, grouped for the initiator.
interface ram_initiator_if;

  logic        reqValidIn;
  logic        reqReadyOut;
  logic        reqRwIn;
  logic [31:0] reqAddrIn;
  logic [31:0] reqDataIn;

  logic        respValidOut;
  logic        respReadyIn;
  logic [31:0] respDataOut;
  logic        respErrOut;

  logic [31:0] memAddrOut;
  logic [31:0] memDataOut;
  logic        memRwOut;
  logic        memTriggerOut;
  logic [31:0] memDataIn;
  logic        memReadyIn;

  modport master (
    input  reqValidIn, reqRwIn, reqAddrIn, reqDataIn, respReadyIn,
           memDataIn, memReadyIn,
    output reqReadyOut, respValidOut, respDataOut, respErrOut,
           memAddrOut, memDataOut, memRwOut, memTriggerOut
  );

  modport slave (
    output reqValidIn, reqRwIn, reqAddrIn, reqDataIn, respReadyIn,
           memDataIn, memReadyIn,
    input  reqReadyOut, respValidOut, respDataOut, respErrOut,
           memAddrOut, memDataOut, memRwOut, memTriggerOut
  );

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchronizer, asynchronously cleared to zero.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clkIn,
  input  logic             rstNIn,
  input  logic [WIDTH-1:0] dIn,
  output logic [WIDTH-1:0] qOut
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      meta <= '0;
      qOut <= '0;
    end else begin
      meta <= dIn;
      qOut <= meta;
    end
  end

endmodule

// File: rtl/ram_initiator.sv
// Initiator for the two-phase trigger/ready RAM: one outstanding access,
// trigger toggle per access, timeout-protected wait on synchronized ready.
module ram_initiator
  import ram_if_pkg::*;
#(
  parameter int unsigned MIN_WAIT = MIN_WAIT_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input logic             clkIn,
  input logic             rstNIn,
  ram_initiator_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_MIN  = cnt_t'(MIN_WAIT - 1);
  localparam cnt_t CNT_LAST = cnt_t'(TIMEOUT - 1);
  localparam cnt_t CNT_SAT  = cnt_t'(TIMEOUT);

  state_t      state, stateNext;
  cnt_t        cnt, cntNext;
  logic [31:0] addrR, addrNext;
  logic [31:0] wdataR, wdataNext;
  logic        rwR, rwNext;
  logic        trigR, trigNext;
  logic [31:0] rdataR, rdataNext;
  logic        errR, errNext;
  logic        readySync;

  // Ready is asynchronous to clkIn; nothing else may look at the raw level.
  sync2 #(.WIDTH(1)) uSyncReady (
    .clkIn  (clkIn),
    .rstNIn (rstNIn),
    .dIn    (bus.memReadyIn),
    .qOut   (readySync)
  );

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state  <= IDLE;
      cnt    <= '0;
      addrR  <= '0;
      wdataR <= '0;
      rwR    <= RW_READ;
      trigR  <= 1'b0;
      rdataR <= '0;
      errR   <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      addrR  <= addrNext;
      wdataR <= wdataNext;
      rwR    <= rwNext;
      trigR  <= trigNext;
      rdataR <= rdataNext;
      errR   <= errNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    addrNext  = addrR;
    wdataNext = wdataR;
    rwNext    = rwR;
    trigNext  = trigR;
    rdataNext = rdataR;
    errNext   = errR;
    unique case (state)
      IDLE: begin
        if (bus.reqValidIn) begin
          addrNext  = bus.reqAddrIn;
          wdataNext = bus.reqDataIn;
          rwNext    = bus.reqRwIn;
          stateNext = SETUP;
        end
      end
      SETUP: begin
        trigNext  = ~trigR;
        cntNext   = '0;
        stateNext = WAIT;
      end
      WAIT: begin
        if (cnt != CNT_SAT) cntNext = cnt + 1'b1;
        // Ready sampled before the flush window may be left over from the previous access.
        if ((cnt >= CNT_MIN) && readySync) begin
          rdataNext = (rwR == RW_READ) ? bus.memDataIn : '0;
          errNext   = 1'b0;
          stateNext = RESP;
        end else if (cnt == CNT_LAST) begin
          rdataNext = '0;
          errNext   = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        if (bus.respReadyIn) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.reqReadyOut   = (state == IDLE);
  assign bus.respValidOut  = (state == RESP);
  assign bus.respDataOut   = rdataR;
  assign bus.respErrOut    = errR;
  assign bus.memAddrOut    = addrR;
  assign bus.memDataOut    = wdataR;
  assign bus.memRwOut      = rwR;
  assign bus.memTriggerOut = trigR;

endmodule

// File: tb/tb_ram_initiator.sv
// Bench for ram_initiator: behavioural byte RAM on the bus, request-level
// reference memory, directed scenarios plus randomized traffic.
module tb_ram_initiator;
  import ram_if_pkg::*;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  ram_initiator_if bus ();

  ram_initiator #(.MIN_WAIT(4), .TIMEOUT(255)) dut (
    .clkIn  (clk),
    .rstNIn (rstN),
    .bus    (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int nCompared = 0;
  int nMismatched = 0;

  logic [7:0]  ramMem [1024];
  logic [7:0]  refMem [1024];
  bit          tieLow = 1'b0;
  int unsigned readyDelay = 3;
  int unsigned toggles = 0;

  // Behavioural RAM: every trigger edge is one access; ready dips briefly, then returns.
  initial begin
    int unsigned a;
    logic [31:0] rd;
    bus.memReadyIn = 1'b1;
    bus.memDataIn  = '0;
    forever begin
      @(bus.memTriggerOut);
      toggles = toggles + 1;
      #1;
      bus.memReadyIn = 1'b0;
      if (!tieLow) begin
        a = int'(bus.memAddrOut[9:0]);
        rd = '0;
        for (int i = 0; i < 4; i++) begin
          if (bus.memRwOut == RW_WRITE) ramMem[(a + i) % 1024] = bus.memDataOut[8*i +: 8];
          else rd[8*i +: 8] = ramMem[(a + i) % 1024];
        end
        bus.memDataIn = rd;
        #(readyDelay);
        bus.memReadyIn = 1'b1;
      end
    end
  end

  function automatic logic [31:0] refRead(input logic [31:0] addr);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = refMem[(int'(addr[9:0]) + i) % 1024];
    return v;
  endfunction

  task automatic refWrite(input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < 4; i++) refMem[(int'(addr[9:0]) + i) % 1024] = data[8*i +: 8];
  endtask

  // One complete transfer; lat is response-visible edge minus accept edge.
  task automatic doReq(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rdata, output logic err, output int lat);
    int n;
    int unsigned accE;
    @(negedge clk);
    bus.reqValidIn = 1'b1;
    bus.reqRwIn    = rw;
    bus.reqAddrIn  = addr;
    bus.reqDataIn  = data;
    n = 0;
    while (!bus.reqReadyOut && n < 50) begin @(negedge clk); n++; end
    if (!bus.reqReadyOut) begin
      nCompared++; nMismatched++;
      $display("FAIL accept_wait: reqReadyOut=%0b required 1 within 50 cycles", bus.reqReadyOut);
    end
    accE = cyc + 1;
    @(negedge clk);
    bus.reqValidIn = 1'b0;
    n = 0;
    while (!bus.respValidOut && n < 400) begin @(negedge clk); n++; end
    if (!bus.respValidOut) begin
      nCompared++; nMismatched++;
      $display("FAIL resp_wait: respValidOut=%0b required 1 within 400 cycles", bus.respValidOut);
    end
    rdata = bus.respDataOut;
    err   = bus.respErrOut;
    lat   = int'(cyc - accE);
  endtask

  task automatic test_reset();
    #12;
    nCompared++;
    if ({bus.reqReadyOut, bus.respValidOut, bus.respErrOut, bus.respDataOut, bus.memAddrOut,
         bus.memDataOut, bus.memRwOut, bus.memTriggerOut} !== {1'b1, 1'b0, 1'b0, 96'h0, 1'b0, 1'b0}) begin
      nMismatched++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b err=%0b data=%h addr=%h wdata=%h rw=%0b trig=%0b required 1 0 0 0 0 0 0 0",
               bus.reqReadyOut, bus.respValidOut, bus.respErrOut, bus.respDataOut, bus.memAddrOut,
               bus.memDataOut, bus.memRwOut, bus.memTriggerOut);
    end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic e; int lat; int unsigned t0;
    t0 = toggles;
    refWrite(32'h10, 32'hDEADBEEF);
    doReq(RW_WRITE, 32'h10, 32'hDEADBEEF, d, e, lat);
    nCompared++;
    if ({e, d} !== {1'b0, 32'h0}) begin
      nMismatched++; $display("FAIL wr_resp: err=%0b data=%h required 0 00000000", e, d);
    end
    nCompared++;
    if (lat !== 5) begin nMismatched++; $display("FAIL wr_latency: got %0d required 5", lat); end
    nCompared++;
    if (toggles - t0 !== 1) begin nMismatched++; $display("FAIL wr_toggles: got %0d required 1", toggles - t0); end
    t0 = toggles;
    doReq(RW_READ, 32'h10, 32'h0, d, e, lat);
    nCompared++;
    if ({e, d} !== {1'b0, refRead(32'h10)}) begin
      nMismatched++; $display("FAIL rd_resp: err=%0b data=%h required 0 %h", e, d, refRead(32'h10));
    end
    nCompared++;
    if (lat !== 5) begin nMismatched++; $display("FAIL rd_latency: got %0d required 5", lat); end
    nCompared++;
    if (toggles - t0 !== 1) begin nMismatched++; $display("FAIL rd_toggles: got %0d required 1", toggles - t0); end
  endtask

  task automatic test_byte_order();
    logic [31:0] d; logic e; int lat;
    refWrite(32'h20, 32'h11223344);
    doReq(RW_WRITE, 32'h20, 32'h11223344, d, e, lat);
    nCompared++;
    if ({ramMem[32], ramMem[33], ramMem[34], ramMem[35]} !== 32'h44332211) begin
      nMismatched++;
      $display("FAIL byte_layout: bytes %h %h %h %h required 44 33 22 11", ramMem[32], ramMem[33], ramMem[34], ramMem[35]);
    end
    doReq(RW_READ, 32'h21, 32'h0, d, e, lat);
    nCompared++;
    if (d[7:0] !== 8'h33) begin nMismatched++; $display("FAIL byte_lane0: got %h required 33", d[7:0]); end
    nCompared++;
    if (d !== refRead(32'h21)) begin nMismatched++; $display("FAIL unaligned_read: got %h required %h", d, refRead(32'h21)); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0; int n;
    @(negedge clk);
    bus.respReadyIn = 1'b0;
    bus.reqValidIn = 1'b1; bus.reqRwIn = RW_READ; bus.reqAddrIn = 32'h20; bus.reqDataIn = '0;
    n = 0;
    while (!bus.reqReadyOut && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.reqValidIn = 1'b0;
    n = 0;
    while (!bus.respValidOut && n < 50) begin @(negedge clk); n++; end
    d0 = bus.respDataOut;
    nCompared++;
    if ({bus.respValidOut, d0} !== {1'b1, refRead(32'h20)}) begin
      nMismatched++; $display("FAIL bp_first: vld=%0b data=%h required 1 %h", bus.respValidOut, d0, refRead(32'h20));
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nCompared++;
      if ({bus.respValidOut, bus.respDataOut, bus.reqReadyOut} !== {1'b1, d0, 1'b0}) begin
        nMismatched++;
        $display("FAIL bp_hold: cycle %0d vld=%0b data=%h rdy=%0b required 1 %h 0", i,
                 bus.respValidOut, bus.respDataOut, bus.reqReadyOut, d0);
      end
    end
    bus.respReadyIn = 1'b1;
    @(negedge clk);
    nCompared++;
    if ({bus.reqReadyOut, bus.respValidOut} !== 2'b10) begin
      nMismatched++; $display("FAIL bp_release: rdy=%0b vld=%0b required 1 0", bus.reqReadyOut, bus.respValidOut);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d; logic e; int lat;
    tieLow = 1'b1;
    doReq(RW_READ, 32'h10, 32'h0, d, e, lat);
    tieLow = 1'b0;
    nCompared++;
    if (lat !== 256) begin nMismatched++; $display("FAIL to_latency: got %0d required 256", lat); end
    nCompared++;
    if ({e, d} !== {1'b1, 32'h0}) begin nMismatched++; $display("FAIL to_resp: err=%0b data=%h required 1 00000000", e, d); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d; logic e; int lat; int n; int seen;
    if (bus.memTriggerOut) doReq(RW_READ, 32'h0, 32'h0, d, e, lat);
    @(negedge clk);
    bus.reqValidIn = 1'b1; bus.reqRwIn = RW_READ; bus.reqAddrIn = 32'h3F0; bus.reqDataIn = '0;
    n = 0;
    while (!bus.reqReadyOut && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.reqValidIn = 1'b0;
    @(negedge clk);
    nCompared++;
    if (bus.memTriggerOut !== 1'b1) begin nMismatched++; $display("FAIL mid_trig: got %0b required 1", bus.memTriggerOut); end
    #2 rstN = 1'b0;
    #1;
    nCompared++;
    if ({bus.reqReadyOut, bus.respValidOut, bus.respErrOut, bus.respDataOut, bus.memAddrOut,
         bus.memDataOut, bus.memRwOut, bus.memTriggerOut} !== {1'b1, 1'b0, 1'b0, 96'h0, 1'b0, 1'b0}) begin
      nMismatched++;
      $display("FAIL mid_reset_outputs: rdy=%0b vld=%0b err=%0b data=%h addr=%h wdata=%h rw=%0b trig=%0b required 1 0 0 0 0 0 0 0",
               bus.reqReadyOut, bus.respValidOut, bus.respErrOut, bus.respDataOut, bus.memAddrOut,
               bus.memDataOut, bus.memRwOut, bus.memTriggerOut);
    end
    @(negedge clk);
    rstN = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (bus.respValidOut) seen++; end
    nCompared++;
    if (seen !== 0) begin nMismatched++; $display("FAIL mid_no_resp: %0d valid cycles, required 0", seen); end
    doReq(RW_READ, 32'h10, 32'h0, d, e, lat);
    nCompared++;
    if ({e, d, lat} !== {1'b0, refRead(32'h10), 32'd5}) begin
      nMismatched++; $display("FAIL post_reset_read: err=%0b data=%h lat=%0d required 0 %h 5", e, d, lat, refRead(32'h10));
    end
  endtask

  task automatic test_stale_ready();
    logic [31:0] d; logic e; int lat;
    readyDelay = 2;
    doReq(RW_READ, 32'h20, 32'h0, d, e, lat);
    nCompared++;
    if ({e, d, lat} !== {1'b0, refRead(32'h20), 32'd5}) begin
      nMismatched++; $display("FAIL stale_ready: err=%0b data=%h lat=%0d required 0 %h 5", e, d, lat, refRead(32'h20));
    end
    readyDelay = 3;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, w, rd; int unsigned acc [2]; int na; int nr; int n;
    a = $urandom_range(0, 1023); w = $urandom;
    refWrite(a, w);
    na = 0; nr = 0; n = 0;
    @(negedge clk);
    bus.reqValidIn = 1'b1; bus.reqRwIn = RW_WRITE; bus.reqAddrIn = a; bus.reqDataIn = w;
    rd = '0;
    while (nr < 2 && n < 60) begin
      if (bus.respValidOut) begin rd = bus.respDataOut; nr++; end
      if (bus.reqValidIn && bus.reqReadyOut) begin
        acc[na] = cyc + 1; na++;
        @(negedge clk);
        if (na == 1) begin bus.reqRwIn = RW_READ; bus.reqDataIn = '0; end
        else bus.reqValidIn = 1'b0;
      end else @(negedge clk);
      n++;
    end
    bus.reqValidIn = 1'b0;
    nCompared++;
    if (na !== 2 || acc[1] - acc[0] !== 7) begin
      nMismatched++; $display("FAIL b2b_spacing: accepts=%0d spacing=%0d required 2 7", na, acc[1] - acc[0]);
    end
    nCompared++;
    if (rd !== refRead(a)) begin nMismatched++; $display("FAIL b2b_read: got %h required %h", rd, refRead(a)); end
  endtask

  task automatic test_random();
    logic [31:0] a, w, d; logic rw, e; int lat;
    for (int i = 0; i < 30; i++) begin
      readyDelay = $urandom_range(1, 8);
      rw = 1'($urandom_range(0, 1));
      a = $urandom; w = $urandom;
      if (rw == RW_WRITE) refWrite(a, w);
      doReq(rw, a, w, d, e, lat);
      nCompared++;
      if ({e, d, lat} !== {1'b0, (rw == RW_WRITE) ? 32'h0 : refRead(a), 32'd5}) begin
        nMismatched++;
        $display("FAIL rnd_resp: i=%0d rw=%0b addr=%h err=%0b data=%h lat=%0d required 0 %h 5", i, rw, a, e, d, lat,
                 (rw == RW_WRITE) ? 32'h0 : refRead(a));
      end
      nCompared++;
      if ({bus.memAddrOut, bus.memDataOut, bus.memRwOut} !== {a, w, rw}) begin
        nMismatched++;
        $display("FAIL rnd_bus_hold: addr=%h data=%h rw=%0b required %h %h %0b", bus.memAddrOut,
                 bus.memDataOut, bus.memRwOut, a, w, rw);
      end
    end
    readyDelay = 3;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin ramMem[i] = '0; refMem[i] = '0; end
    bus.reqValidIn = 1'b0; bus.reqRwIn = RW_READ; bus.reqAddrIn = '0; bus.reqDataIn = '0;
    bus.respReadyIn = 1'b1;
    test_reset();
    test_write_read();
    test_byte_order();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_stale_ready();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_initiator.md
# ram_initiator

Clocked initiator for the two-phase trigger/ready RAM interface. It accepts word read/write requests from the core over a valid/ready channel and drives address, write data and direction onto the RAM bus. It then toggles the trigger line, waits for the RAM's ready level and returns read data or a write acknowledge over a valid/ready response channel. It sits between the pipeline's memory stage and the 1 KB byte-addressed RAM, and is the only driver of that RAM's inputs.

## Interface
- MIN_WAIT, 4: cycles in WAIT before ready may complete a transfer; legal minimum 3, which flushes the stale ready through the synchronizer.
- TIMEOUT, 255: WAIT cycles after which the transfer is aborted with error; must be greater than MIN_WAIT.
- clkIn  input  1  single clock
- rstNIn  input  1  reset, asynchronous assert, active-low
- reqValidIn  input  1  request present
- reqReadyOut  output  1  request accepted when high with reqValidIn
- reqRwIn  input  1  0 = read, 1 = write
- reqAddrIn  input  32  byte address, passed through unmodified
- reqDataIn  input  32  write data, little-endian byte order in RAM
- respValidOut  output  1  response present
- respReadyIn  input  1  response consumed
- respDataOut  output  32  read data; 0 for writes and errors
- respErrOut  output  1  timeout flag, qualified by respValidOut
- memAddrOut  output  32  to RAM address
- memDataOut  output  32  to RAM write data
- memRwOut  output  1  to RAM direction
- memTriggerOut  output  1  to RAM trigger; each toggle is one access
- memDataIn  input  32  from RAM read data
- memReadyIn  input  1  from RAM ready, asynchronous level

## Operation
- FSM states: IDLE, SETUP, WAIT, RESP.
- IDLE: reqReadyOut=1. On reqValidIn, register addr/data/rw into the mem*Out registers and go to SETUP.
- SETUP: bus outputs are stable for one full cycle. Toggle memTriggerOut, clear the wait counter, go to WAIT.
- WAIT: counter increments each cycle, saturating at TIMEOUT.
  - If counter ≥ MIN_WAIT−1 and the synchronized ready is 1: for a read, capture memDataIn into respDataOut. Set respErrOut=0 and go to RESP.
  - Else if counter = TIMEOUT−1: set respDataOut=0 and respErrOut=1, go to RESP.
- RESP: respValidOut=1. Hold data and error until respReadyIn, then go to IDLE.
- The RAM's ready-low pulse may be narrower than a clock period. Completion therefore never depends on observing ready low; only the MIN_WAIT flush plus a ready-high level counts.
- mem*Out hold their values in all states after SETUP until the next accept.
- Reset: state=IDLE; reqReadyOut=1; respValidOut=0; respErrOut=0; respDataOut=0; memAddrOut=0; memDataOut=0; memRwOut=0; memTriggerOut=0; synchronizer=0.
- Reset mid-operation: if memTriggerOut was 1, the drop to 0 is an edge the RAM treats as an access. memRwOut resets to 0 in the same event, so that access is a harmless read of address 0. No response is issued for the aborted request.

## Timing
- Request accepted at edge E0 → bus outputs valid after E0 → trigger toggles at E1 → earliest completion at E(1+MIN_WAIT).
- With MIN_WAIT=4, respValidOut rises 5 cycles after the accept edge.
- Throughput: one outstanding transfer. No accept while in SETUP, WAIT or RESP, including the cycle a response handshakes. Minimum 7 cycles per transfer with the default MIN_WAIT.
- Timeout: respValidOut rises at E(1+TIMEOUT) when ready never returns high.
- memReadyIn passes through a 2-flop synchronizer and is used by nothing else.

## Structure
- Shared package ram_if_pkg holds the state enum (IDLE, SETUP, WAIT, RESP), the default MIN_WAIT and TIMEOUT constants, and the read/write encoding constants (RW_READ=0, RW_WRITE=1).
- One sub-module: sync2, a generic 2-flop synchronizer with async active-low reset to 0, used for memReadyIn.
- Counter width is $clog2(TIMEOUT+1).

## Test plan
- Write then read: write 0xDEADBEEF to address 0x10, then read 0x10 against the behavioral RAM → one trigger toggle per request; read returns 0xDEADBEEF with respErrOut=0; each respValidOut rises 5 cycles after its accept.
- Byte order: write 0x11223344 to 0x20 → RAM bytes at 0x20..0x23 = 0x44, 0x33, 0x22, 0x11; a read of 0x21 returns byte 0x33 in bits [7:0].
- Backpressure: hold respReadyIn=0 for 10 cycles after a read completes → respValidOut and respDataOut stay stable and reqReadyOut stays 0 throughout; IDLE is entered the cycle after respReadyIn=1.
- Timeout: tie memReadyIn=0 and issue a read → respValidOut rises 256 cycles after accept with respErrOut=1 and respDataOut=0.
- Reset mid-WAIT: assert rstNIn while memTriggerOut=1 → all outputs take their reset values immediately; memRwOut=0; no response; the next request completes normally.
- Stale ready: memReadyIn held at 1 before the trigger and the RAM drops it for under 1 clock → completion still no earlier than E(1+MIN_WAIT) and read data matches RAM contents.
